// File: rtl/spi_slave.sv
// 16-bit CPHA=1 SPI slave (modes 1 and 3), oversampled on sys_clk.
// Optional feature macro: SPI_SLAVE_ABORT_EN adds the spi_abort pulse output.
module spi_slave #(
    parameter int DATA_W   = 16,
    parameter int SYNC_STG = 2
) (
    input  logic              sys_clk,
    input  logic              rst_n,
    input  logic [1:0]        spi_mode,
    input  logic [DATA_W-1:0] spi_sdata,
    output logic [DATA_W-1:0] spi_rdata,
    output logic              spi_done,
    output logic              spi_busy,
    input  logic              spi_csn,
    input  logic              spi_clk,
    input  logic              spi_mosi,
`ifdef SPI_SLAVE_ABORT_EN
    output logic              spi_abort,
`endif
    output logic              spi_miso
);

    localparam int                CNT_W    = $clog2(DATA_W);
    localparam logic [CNT_W-1:0]  LAST_BIT = CNT_W'(DATA_W - 1);

    typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE, S_WAIT} state_e;

    state_e              state_q;
    logic [SYNC_STG-1:0] clk_sync_q, csn_sync_q, mosi_sync_q;
    logic                clk_prev_q;
    logic                armed_q;
    logic                cpol_q;
    logic [CNT_W-1:0]    bit_cnt_q;
    logic [DATA_W-1:0]   tx_buf_q, rx_buf_q, rdata_q;
    logic                done_q, abort_q, miso_q;

    logic clk_s, csn_s, mosi_s, rise, fall, lead, trail;

    // NOTE: csn sync flops reset to 0 so a csn already low at reset release
    // never looks like a high; armed_q only sets once a real high propagates.
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            clk_sync_q  <= '0;
            csn_sync_q  <= '0;
            mosi_sync_q <= '0;
            clk_prev_q  <= 1'b0;
        end else begin
            clk_sync_q  <= {clk_sync_q[SYNC_STG-2:0], spi_clk};
            csn_sync_q  <= {csn_sync_q[SYNC_STG-2:0], spi_csn};
            mosi_sync_q <= {mosi_sync_q[SYNC_STG-2:0], spi_mosi};
            clk_prev_q  <= clk_sync_q[SYNC_STG-1];
        end
    end

    always_comb begin
        clk_s  = clk_sync_q[SYNC_STG-1];
        csn_s  = csn_sync_q[SYNC_STG-1];
        mosi_s = mosi_sync_q[SYNC_STG-1];
        rise   = clk_s & ~clk_prev_q;
        fall   = ~clk_s & clk_prev_q;
        lead   = cpol_q ? fall : rise;
        trail  = cpol_q ? rise : fall;
    end

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            armed_q   <= 1'b0;
            cpol_q    <= 1'b0;
            bit_cnt_q <= '0;
            tx_buf_q  <= '0;
            rx_buf_q  <= '0;
            rdata_q   <= '0;
            done_q    <= 1'b0;
            abort_q   <= 1'b0;
            miso_q    <= 1'b0;
        end else begin
            done_q  <= 1'b0;
            abort_q <= 1'b0;
            if (csn_s) armed_q <= 1'b1;
            case (state_q)
                S_IDLE: begin
                    miso_q <= 1'b0;
                    if (!csn_s && armed_q) begin
                        state_q   <= S_SHIFT;
                        tx_buf_q  <= spi_sdata;
                        cpol_q    <= (spi_mode == 2'd3);
                        bit_cnt_q <= '0;
                        armed_q   <= 1'b0;
                    end
                end
                S_SHIFT: begin
                    // csn high beats a coincident trail: the frame is dropped.
                    if (csn_s) begin
                        state_q <= S_IDLE;
                        miso_q  <= 1'b0;
                        abort_q <= 1'b1;
                    end else if (lead) begin
                        miso_q   <= tx_buf_q[DATA_W-1];
                        tx_buf_q <= {tx_buf_q[DATA_W-2:0], 1'b0};
                    end else if (trail) begin
                        rx_buf_q <= {rx_buf_q[DATA_W-2:0], mosi_s};
                        if (bit_cnt_q == LAST_BIT) state_q <= S_DONE;
                        else bit_cnt_q <= bit_cnt_q + 1'b1;
                    end
                end
                S_DONE: begin
                    rdata_q <= rx_buf_q;
                    done_q  <= 1'b1;
                    state_q <= S_WAIT;
                end
                default: begin
                    if (csn_s) begin
                        state_q <= S_IDLE;
                        miso_q  <= 1'b0;
                    end
                end
            endcase
        end
    end

    assign spi_rdata = rdata_q;
    assign spi_done  = done_q;
    assign spi_busy  = (state_q != S_IDLE);
    assign spi_miso  = miso_q;
`ifdef SPI_SLAVE_ABORT_EN
    assign spi_abort = abort_q;
`else
    logic unused_abort;
    assign unused_abort = abort_q;
`endif

endmodule

// File: tb/tb_spi_slave.sv
// Directed testbench for spi_slave; a behavioural CPHA=1 master drives the pins.
module tb_spi_slave;

    localparam int HALF = 10;  // sys_clk cycles per SPI half period

    logic        sys_clk = 1'b0;
    logic        rst_n   = 1'b0;
    logic [1:0]  spi_mode  = 2'd1;
    logic [15:0] spi_sdata = '0;
    logic [15:0] spi_rdata;
    logic        spi_done, spi_busy, spi_miso;
    logic        spi_csn  = 1'b1;
    logic        spi_clk  = 1'b0;
    logic        spi_mosi = 1'b0;
`ifdef SPI_SLAVE_ABORT_EN
    logic        spi_abort;
`endif

    int pass_cnt  = 0;
    int total_cnt = 0;
    int done_cnt  = 0;
    int abort_cnt = 0;
    logic [15:0] last_done_rdata = '0;
    logic [15:0] prev_done_rdata = '0;

    spi_slave dut (
        .sys_clk  (sys_clk),
        .rst_n    (rst_n),
        .spi_mode (spi_mode),
        .spi_sdata(spi_sdata),
        .spi_rdata(spi_rdata),
        .spi_done (spi_done),
        .spi_busy (spi_busy),
        .spi_csn  (spi_csn),
        .spi_clk  (spi_clk),
        .spi_mosi (spi_mosi),
`ifdef SPI_SLAVE_ABORT_EN
        .spi_abort(spi_abort),
`endif
        .spi_miso (spi_miso)
    );

    always #10 sys_clk = ~sys_clk;

    always @(negedge sys_clk) begin
        if (spi_done) begin
            done_cnt++;
            prev_done_rdata = last_done_rdata;
            last_done_rdata = spi_rdata;
        end
`ifdef SPI_SLAVE_ABORT_EN
        if (spi_abort) abort_cnt++;
`endif
    end

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge sys_clk);
    endtask

    // CPHA=1 master: shift MOSI on lead, sample MISO on trail, MSB first.
    task automatic spi_xfer(input logic [1:0] mode, input logic [15:0] tx, input int nbits,
                            input bit end_csn, input int gap, output logic [15:0] rx);
        logic cpol;
        cpol = (mode == 2'd3);
        rx = '0;
        spi_mode = mode;
        if (spi_clk !== cpol) begin
            spi_clk = cpol;
            wait_cyc(10);
        end
        spi_csn = 1'b0;
        wait_cyc(HALF);
        for (int i = 0; i < nbits; i++) begin
            spi_clk  = ~cpol;
            spi_mosi = tx[15-i];
            wait_cyc(HALF);
            rx = {rx[14:0], spi_miso};
            spi_clk = cpol;
            wait_cyc(HALF);
        end
        if (end_csn) begin
            spi_csn = 1'b1;
            wait_cyc(gap);
        end
    endtask

    task automatic test_reset;
        wait_cyc(5);
        total_cnt++; if (spi_rdata !== 16'h0) $display("FAIL rst_rdata got %h exp 0000", spi_rdata); else pass_cnt++;
        total_cnt++; if (spi_done !== 1'b0) $display("FAIL rst_done got %b exp 0", spi_done); else pass_cnt++;
        total_cnt++; if (spi_busy !== 1'b0) $display("FAIL rst_busy got %b exp 0", spi_busy); else pass_cnt++;
        total_cnt++; if (spi_miso !== 1'b0) $display("FAIL rst_miso got %b exp 0", spi_miso); else pass_cnt++;
        rst_n = 1'b1;
        wait_cyc(10);
        total_cnt++; if (spi_busy !== 1'b0) $display("FAIL rst_rel_busy got %b exp 0", spi_busy); else pass_cnt++;
    endtask

    task automatic test_mode1;
        logic [15:0] rx;
        int d0;
        d0 = done_cnt;
        spi_sdata = 16'h3C5A;
        spi_xfer(2'd1, 16'hA5C3, 16, 1'b1, 20, rx);
        total_cnt++; if (spi_rdata !== 16'hA5C3) $display("FAIL m1_rdata got %h exp a5c3", spi_rdata); else pass_cnt++;
        total_cnt++; if (rx !== 16'h3C5A) $display("FAIL m1_master_rx got %h exp 3c5a", rx); else pass_cnt++;
        total_cnt++; if (done_cnt - d0 !== 1) $display("FAIL m1_done_pulses got %0d exp 1", done_cnt - d0); else pass_cnt++;
        total_cnt++; if (spi_busy !== 1'b0) $display("FAIL m1_busy_after got %b exp 0", spi_busy); else pass_cnt++;
    endtask

    task automatic test_mode3;
        logic [15:0] rx;
        int d0;
        d0 = done_cnt;
        spi_sdata = 16'h0001;
        spi_xfer(2'd3, 16'hFFFF, 16, 1'b1, 20, rx);
        total_cnt++; if (spi_rdata !== 16'hFFFF) $display("FAIL m3_rdata got %h exp ffff", spi_rdata); else pass_cnt++;
        total_cnt++; if (rx !== 16'h0001) $display("FAIL m3_master_rx got %h exp 0001", rx); else pass_cnt++;
        total_cnt++; if (done_cnt - d0 !== 1) $display("FAIL m3_done_pulses got %0d exp 1", done_cnt - d0); else pass_cnt++;
    endtask

    task automatic test_abort;
        logic [15:0] rx;
        int d0, a0;
        // mode 0 is treated as mode 1
        spi_sdata = 16'h8001;
        spi_xfer(2'd0, 16'h1234, 16, 1'b1, 20, rx);
        total_cnt++; if (spi_rdata !== 16'h1234) $display("FAIL ab_setup_rdata got %h exp 1234", spi_rdata); else pass_cnt++;
        total_cnt++; if (rx !== 16'h8001) $display("FAIL ab_mode0_rx got %h exp 8001", rx); else pass_cnt++;
        d0 = done_cnt;
        a0 = abort_cnt;
        spi_sdata = 16'hFFFF;
        spi_xfer(2'd1, 16'hABCD, 7, 1'b1, 20, rx);
        total_cnt++; if (spi_rdata !== 16'h1234) $display("FAIL ab_rdata got %h exp 1234", spi_rdata); else pass_cnt++;
        total_cnt++; if (done_cnt - d0 !== 0) $display("FAIL ab_done_pulses got %0d exp 0", done_cnt - d0); else pass_cnt++;
        total_cnt++; if (spi_miso !== 1'b0) $display("FAIL ab_miso_idle got %b exp 0", spi_miso); else pass_cnt++;
        total_cnt++; if (spi_busy !== 1'b0) $display("FAIL ab_busy got %b exp 0", spi_busy); else pass_cnt++;
`ifdef SPI_SLAVE_ABORT_EN
        total_cnt++; if (abort_cnt - a0 !== 1) $display("FAIL ab_abort_pulses got %0d exp 1", abort_cnt - a0); else pass_cnt++;
`endif
    endtask

    task automatic test_back_to_back;
        logic [15:0] rx;
        int d0;
        d0 = done_cnt;
        spi_sdata = 16'h5A5A;
        spi_xfer(2'd1, 16'h0F0F, 16, 1'b1, 8, rx);
        spi_xfer(2'd1, 16'hF0F0, 16, 1'b1, 20, rx);
        total_cnt++; if (done_cnt - d0 !== 2) $display("FAIL b2b_done_pulses got %0d exp 2", done_cnt - d0); else pass_cnt++;
        total_cnt++; if (prev_done_rdata !== 16'h0F0F) $display("FAIL b2b_first got %h exp 0f0f", prev_done_rdata); else pass_cnt++;
        total_cnt++; if (last_done_rdata !== 16'hF0F0) $display("FAIL b2b_second got %h exp f0f0", last_done_rdata); else pass_cnt++;
        total_cnt++; if (rx !== 16'h5A5A) $display("FAIL b2b_master_rx got %h exp 5a5a", rx); else pass_cnt++;
    endtask

    task automatic test_sdata_change;
        logic [15:0] rx;
        spi_sdata = 16'h1111;
        fork
            spi_xfer(2'd1, 16'h5555, 16, 1'b1, 20, rx);
            begin
                wait_cyc(HALF * 2 * 4);
                spi_sdata = 16'h2222;
                spi_mode  = 2'd3;
            end
        join
        total_cnt++; if (rx !== 16'h1111) $display("FAIL sd_master_rx got %h exp 1111", rx); else pass_cnt++;
        total_cnt++; if (spi_rdata !== 16'h5555) $display("FAIL sd_rdata got %h exp 5555", spi_rdata); else pass_cnt++;
    endtask

    task automatic test_reset_midframe;
        logic [15:0] rx;
        int d0;
        spi_sdata = 16'hC3C3;
        spi_xfer(2'd1, 16'h9999, 5, 1'b0, 0, rx);
        total_cnt++; if (spi_busy !== 1'b1) $display("FAIL mr_busy_pre got %b exp 1", spi_busy); else pass_cnt++;
        rst_n = 1'b0;
        wait_cyc(3);
        total_cnt++; if (spi_rdata !== 16'h0) $display("FAIL mr_rdata got %h exp 0000", spi_rdata); else pass_cnt++;
        total_cnt++; if (spi_busy !== 1'b0) $display("FAIL mr_busy got %b exp 0", spi_busy); else pass_cnt++;
        total_cnt++; if (spi_miso !== 1'b0) $display("FAIL mr_miso got %b exp 0", spi_miso); else pass_cnt++;
        total_cnt++; if (spi_done !== 1'b0) $display("FAIL mr_done got %b exp 0", spi_done); else pass_cnt++;
        rst_n = 1'b1;
        // csn still low at release: no frame may start without a fresh fall
        for (int i = 0; i < 3; i++) begin
            spi_clk = 1'b1; wait_cyc(HALF);
            spi_clk = 1'b0; wait_cyc(HALF);
        end
        total_cnt++; if (spi_busy !== 1'b0) $display("FAIL mr_no_stale_start got %b exp 0", spi_busy); else pass_cnt++;
        spi_csn = 1'b1;
        wait_cyc(10);
        d0 = done_cnt;
        spi_sdata = 16'h7E81;
        spi_xfer(2'd1, 16'hBEEF, 16, 1'b1, 20, rx);
        total_cnt++; if (spi_rdata !== 16'hBEEF) $display("FAIL mr_rdata_after got %h exp beef", spi_rdata); else pass_cnt++;
        total_cnt++; if (rx !== 16'h7E81) $display("FAIL mr_master_rx got %h exp 7e81", rx); else pass_cnt++;
        total_cnt++; if (done_cnt - d0 !== 1) $display("FAIL mr_done_pulses got %0d exp 1", done_cnt - d0); else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_mode1();
        test_mode3();
        test_abort();
        test_back_to_back();
        test_sdata_change();
        test_reset_midframe();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
